// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: two-cycle FETCH/EXEC sequencer around an external ALU.
// Holds A, D, PC and IR, decodes ALU controls, and resolves write-back, memory writes and jumps.
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  output logic [14:0] pc,
  input  logic [15:0] in_m,
  input  logic        mem_wait,
  output logic [14:0] address_m,
  output logic [15:0] out_m,
  output logic        write_m,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t      state, state_nxt;
  logic [15:0] a_reg, d_reg, ir;
  logic [14:0] pc_reg;
  logic        is_c, commit, jmp;

  assign is_c   = ir[15];
  assign commit = (state == EXEC) && !mem_wait;
  assign jmp    = is_c & ((ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // write_m is gated by rst so an abandoned store drops with the reset itself.
  always_comb begin
    state_nxt = state;
    write_m   = 1'b0;
    case (state)
      FETCH: state_nxt = EXEC;
      EXEC: begin
        write_m = is_c & ir[3] & ~rst;
        if (!mem_wait) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // All commit-time writes see pre-commit A, so the jump target is the old A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= 16'h0000;
      d_reg  <= 16'h0000;
      ir     <= 16'h0000;
      pc_reg <= RESET_PC;
    end else begin
      if (state == FETCH) ir <= instr;
      if (commit) begin
        if (!is_c) begin
          a_reg <= ir;
        end else begin
          if (ir[5]) a_reg <= alu_out;
          if (ir[4]) d_reg <= alu_out;
        end
        pc_reg <= jmp ? a_reg[14:0] : pc_reg + 15'd1;
      end
    end
  end

  assign pc        = pc_reg;
  assign address_m = a_reg[14:0];
  assign out_m     = alu_out;
  assign alu_x     = d_reg;
  assign alu_y     = (is_c && ir[12]) ? in_m : a_reg;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = is_c ? ir[11:6] : 6'b000000;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: supplies a bit-level ALU, drives directed and random instructions,
// and checks against an instruction-level model built from the Hack comp-mnemonic table.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr, in_m, out_m, alu_x, alu_y, alu_out;
  logic [14:0] pc, address_m;
  logic        mem_wait, write_m, alu_zr, alu_ng;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;

  int checks = 0;
  int errors = 0;
  int wm_cycles;
  logic [15:0] last_out;

  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc), .in_m(in_m), .mem_wait(mem_wait),
    .address_m(address_m), .out_m(out_m), .write_m(write_m), .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f),
    .alu_no(alu_no), .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
  );

  // External Hack ALU, bit-level.
  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = alu_zx ? 16'h0000 : alu_x;
    if (alu_nx) ax = ~ax;
    ay = alu_zy ? 16'h0000 : alu_y;
    if (alu_ny) ay = ~ay;
    ao = alu_f ? ax + ay : ax & ay;
    if (alu_no) ao = ~ao;
  end
  assign alu_out = ao;
  assign alu_zr  = (ao == 16'h0000);
  assign alu_ng  = ao[15];

  localparam logic [5:0] CODES [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  // Mnemonic-level meaning of each comp code (x = D, y = A or M).
  function automatic logic [15:0] comp(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return 16'd0 - x;
      6'b110011: return 16'd0 - y;
      6'b011111: return x + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return x - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return x + y;
      6'b010011: return x - y;
      6'b000111: return y - x;
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered mid-FETCH; returns mid-FETCH of the following instruction.
  task automatic run_instr(input logic [15:0] ins, input int waits);
    logic [15:0] y, r;
    logic        taken;
    instr    = ins;
    mem_wait = 1'($urandom);
    #1;
    chk("fetch_wm", {15'b0, write_m}, 16'h0000);
    chk("fetch_pc", {1'b0, pc}, {1'b0, m_pc});
    @(posedge clk); #1;
    wm_cycles = 0;
    r = 16'h0000;
    for (int k = 0; k <= waits; k++) begin
      mem_wait = (k < waits);
      in_m     = 16'($urandom);
      #1;
      y = ins[12] ? in_m : m_a;
      r = comp(ins[11:6], m_d, y);
      if (ins[15]) begin
        chk("exec_outm", out_m, r);
        chk("exec_wm", {15'b0, write_m}, {15'b0, ins[3]});
      end else begin
        chk("exec_wm", {15'b0, write_m}, 16'h0000);
      end
      chk("exec_addr", {1'b0, address_m}, {1'b0, m_a[14:0]});
      chk("exec_pc", {1'b0, pc}, {1'b0, m_pc});
      if (write_m) wm_cycles++;
      last_out = out_m;
      @(posedge clk); #1;
    end
    mem_wait = 1'b0;
    if (!ins[15]) begin
      m_a  = ins;
      m_pc = m_pc + 15'd1;
    end else begin
      taken = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'h0000) || (ins[0] && $signed(r) > 0);
      m_pc  = taken ? m_a[14:0] : m_pc + 15'd1;
      if (ins[5]) m_a = r;
      if (ins[4]) m_d = r;
    end
    chk("post_pc", {1'b0, pc}, {1'b0, m_pc});
    chk("post_a", {1'b0, address_m}, {1'b0, m_a[14:0]});
    chk("post_d", alu_x, m_d);
  endtask

  initial begin
    logic [15:0] ins;
    rst = 1'b1; instr = 16'h0000; in_m = 16'h0000; mem_wait = 1'b0;
    m_a = 16'h0000; m_d = 16'h0000; m_pc = 15'h0000;
    #12;
    chk("rst_pc", {1'b0, pc}, 16'h0000);
    chk("rst_wm", {15'b0, write_m}, 16'h0000);
    chk("rst_addr", {1'b0, address_m}, 16'h0000);
    chk("rst_x", alu_x, 16'h0000);
    chk("rst_y", alu_y, 16'h0000);
    chk("rst_ctl", {10'b0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 16'h0000);
    rst = 1'b0;

    // Load and move
    run_instr(16'h0005, 0);
    run_instr(16'hEC10, 0);
    chk("mv_d", alu_x, 16'h0005);
    chk("mv_a", {1'b0, address_m}, 16'h0005);
    chk("mv_pc", {1'b0, pc}, 16'h0002);

    // M=D
    run_instr(16'hE308, 0);
    chk("md_wm", 16'(wm_cycles), 16'd1);
    chk("md_outm", last_out, 16'h0005);
    chk("md_d", alu_x, 16'h0005);

    // Jumps
    run_instr(16'h0010, 0);
    run_instr(16'hEA90, 0);
    run_instr(16'hE302, 0);
    chk("jeq_taken", {1'b0, pc}, 16'h0010);
    run_instr(16'h0010, 0);
    run_instr(16'hEFD0, 0);
    run_instr(16'hE302, 0);
    chk("jeq_not", {1'b0, pc}, 16'h0013);
    run_instr(16'hEE90, 0);
    run_instr(16'hE301, 0);
    chk("jgt_not", {1'b0, pc}, 16'h0015);

    // Wait stretch
    run_instr(16'h0003, 0);
    run_instr(16'hEC10, 0);
    run_instr(16'h0007, 0);
    run_instr(16'hE7C8, 3);
    chk("wait_wm", 16'(wm_cycles), 16'd4);
    chk("wait_outm", last_out, 16'h0004);
    chk("wait_pc", {1'b0, pc}, 16'h0019);
    chk("wait_d", alu_x, 16'h0003);

    // PC wrap via 0;JMP to 7FFF
    run_instr(16'h7FFF, 0);
    run_instr(16'hEA87, 0);
    chk("jmp_pc", {1'b0, pc}, 16'h7FFF);
    run_instr(16'h0001, 0);
    chk("wrap_pc", {1'b0, pc}, 16'h0000);
    chk("wrap_a", {1'b0, address_m}, 16'h0001);

    // Reset in the middle of a store
    run_instr(16'h0009, 0);
    instr = 16'hE308;
    @(posedge clk); #1;
    chk("mid_wm_pre", {15'b0, write_m}, 16'h0001);
    rst = 1'b1;
    #1;
    chk("mid_wm_rst", {15'b0, write_m}, 16'h0000);
    chk("mid_pc", {1'b0, pc}, 16'h0000);
    chk("mid_addr", {1'b0, address_m}, 16'h0000);
    chk("mid_x", alu_x, 16'h0000);
    chk("mid_y", alu_y, 16'h0000);
    #1;
    rst = 1'b0;
    m_a = 16'h0000; m_d = 16'h0000; m_pc = 15'h0000;
    run_instr(16'h0042, 0);
    chk("after_rst_a", {1'b0, address_m}, 16'h0042);

    // Random programs
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0)
        ins = {1'b0, 15'($urandom)};
      else
        ins = {3'b111, 1'($urandom), CODES[$urandom_range(0, 17)], 3'($urandom), 3'($urandom)};
      run_instr(ins, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
